// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures (short/double/long/repeat) into a one-entry valid/ready event register.
// Events appear one cycle after the deciding edge; a full, unaccepted register drops new events and pulses ev_drop.
module key_event_decoder #(
  parameter int LONG_CYC   = 50_000_000,
  parameter int GAP_CYC    = 15_000_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int CW         = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_level,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  input  logic       ev_ready,
  output logic       ev_drop,
  output logic       key_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYC - 1);

  localparam logic [1:0] EV_SHORT  = 2'b00;
  localparam logic [1:0] EV_DOUBLE = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
  localparam logic [1:0] EV_REPEAT = 2'b11;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            new_ev;
  logic [1:0]      new_code;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    new_ev    = 1'b0;
    new_code  = EV_SHORT;
    case (state)
      IDLE: begin
        if (key_level) begin
          state_nxt = PRESS1;
          cnt_nxt   = '0;
        end
      end
      PRESS1: begin
        if (key_level) begin
          if (cnt == LONG_LAST) begin
            new_ev    = 1'b1;
            new_code  = EV_LONG;
            state_nxt = HOLD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (key_level) begin
          new_ev    = 1'b1;
          new_code  = EV_DOUBLE;
          state_nxt = PRESS2;
        end else if (cnt == GAP_LAST) begin
          new_ev    = 1'b1;
          new_code  = EV_SHORT;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESS2: begin
        // no long/repeat detection once a gesture has been classified as double
        if (!key_level) state_nxt = IDLE;
      end
      HOLD: begin
        if (key_level) begin
          if (cnt == REPEAT_LAST) begin
            new_ev   = 1'b1;
            new_code = EV_REPEAT;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      key_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      key_busy <= (state_nxt != IDLE);
    end
  end

  // accept and load on the same edge keeps ev_valid high for back-to-back events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid <= 1'b0;
      ev_code  <= EV_SHORT;
      ev_drop  <= 1'b0;
    end else begin
      ev_drop <= 1'b0;
      if (new_ev) begin
        if (!ev_valid || ev_ready) begin
          ev_valid <= 1'b1;
          ev_code  <= new_code;
        end else begin
          ev_drop <= 1'b1;
        end
      end else if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule
